// File: rtl/cache_refill_assembler_if.sv
// Refill assembler bus: word responses in, assembled cache line out.
// The master drives responses and consumes lines; the slave is the assembler.
interface cache_refill_assembler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned IDX_W  = $clog2(WORDS)
);
    logic                     istream_val;
    logic                     istream_rdy;
    logic [DATA_W-1:0]        istream_data;
    logic [IDX_W-1:0]         istream_idx;
    logic                     ostream_val;
    logic                     ostream_rdy;
    logic [DATA_W*WORDS-1:0]  ostream_line;

    modport master (
        output istream_val, istream_data, istream_idx, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_line
    );

    modport slave (
        input  istream_val, istream_data, istream_idx, ostream_rdy,
        output istream_rdy, ostream_val, ostream_line
    );
endinterface

// File: rtl/cache_refill_assembler.sv
// Gathers out-of-order refill words into a full cache line and hands the line
// to the cache control unit; duplicates are dropped and flagged.
module cache_refill_assembler #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned IDX_W  = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    cache_refill_assembler_if.slave bus,
    input  logic                   clear,
    output logic [IDX_W:0]         fill_count,
    output logic                   err_dup
);
    localparam int unsigned LINE_W = DATA_W * WORDS;
    localparam int unsigned CNT_W  = IDX_W + 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WORDS-1:0]    mask_q,  mask_d;
    logic [LINE_W-1:0]   line_q,  line_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q,   err_d;
    logic                accept;

    // Ready is a decode of state, additionally gated while reset is held low.
    assign bus.istream_rdy  = reset && (state_q == S_FILL);
    assign bus.ostream_val  = (state_q == S_FULL);
    assign bus.ostream_line = line_q;
    assign fill_count       = count_q;
    assign err_dup          = err_q;
    assign accept           = bus.istream_val && bus.istream_rdy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            mask_q  <= '0;
            line_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            line_q  <= line_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        line_d  = line_q;
        count_d = count_q;
        err_d   = err_q;

        // clear wins over both handshakes; a line offered now is not consumed
        if (clear) begin
            state_d = S_FILL;
            mask_d  = '0;
            line_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else if (state_q == S_FILL) begin
            if (accept) begin
                if (mask_q[bus.istream_idx]) begin
                    err_d = 1'b1;
                end else begin
                    mask_d[bus.istream_idx] = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (bus.istream_idx == IDX_W'(i)) begin
                            line_d[i*DATA_W +: DATA_W] = bus.istream_data;
                        end
                    end
                    if (&mask_d) begin
                        state_d = S_FULL;
                    end
                end
            end
        end else if (bus.ostream_rdy) begin
            // line register keeps stale data; it is overwritten by the next refill
            state_d = S_FILL;
            mask_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end
    end
endmodule

// File: tb/tb_cache_refill_assembler.sv
// Bench for cache_refill_assembler: directed scenarios plus random traffic,
// checked every cycle against a word-array model of the refill line.
module tb_cache_refill_assembler;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LINE_W = DATA_W * WORDS;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [IDX_W:0]   fill_count;
    logic             err_dup;

    cache_refill_assembler_if #(.DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W)) bus ();

    cache_refill_assembler #(.DATA_W(DATA_W), .WORDS(WORDS), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .clear      (clear),
        .fill_count (fill_count),
        .err_dup    (err_dup)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Model: which slots hold data, their contents, and whether a line is waiting.
    bit                seen [WORDS];
    logic [DATA_W-1:0] words[WORDS];
    int                cnt_m;
    bit                err_m;
    bit                full_m;
    int                deliv_m   = 0;
    int                deliv_dut = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [LINE_W-1:0] model_line();
        logic [LINE_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) r[i*DATA_W +: DATA_W] = words[i];
        return r;
    endfunction

    function automatic void model_empty(input bit wipe_data);
        for (int i = 0; i < WORDS; i++) begin
            seen[i] = 1'b0;
            if (wipe_data) words[i] = '0;
        end
        cnt_m  = 0;
        err_m  = 1'b0;
        full_m = 1'b0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            model_empty(1'b1);
        end else if (!full_m) begin
            if (bus.istream_val) begin
                if (seen[bus.istream_idx]) begin
                    err_m = 1'b1;
                end else begin
                    seen[bus.istream_idx]  = 1'b1;
                    words[bus.istream_idx] = bus.istream_data;
                    cnt_m++;
                    full_m = (cnt_m == WORDS);
                end
            end
        end else if (bus.ostream_rdy) begin
            deliv_m++;
            model_empty(1'b0);
        end
    end

    // Lines actually handed over by the DUT (old output values at the edge).
    always @(posedge clk) begin
        if (reset && !clear && bus.ostream_val && bus.ostream_rdy) deliv_dut++;
    end

    always @(negedge clk) begin
        check("ostream_val", LINE_W'(bus.ostream_val), LINE_W'(full_m));
        check("istream_rdy", LINE_W'(bus.istream_rdy), LINE_W'(reset && !full_m));
        check("fill_count",  LINE_W'(fill_count),      LINE_W'(cnt_m));
        check("err_dup",     LINE_W'(err_dup),         LINE_W'(err_m));
        if (full_m) check("ostream_line", bus.ostream_line, model_line());
    end

    task automatic drive(input bit v, input int idx, input logic [DATA_W-1:0] d,
                         input bit ordy, input bit clr);
        bus.istream_val  = v;
        bus.istream_idx  = IDX_W'(idx);
        bus.istream_data = d;
        bus.ostream_rdy  = ordy;
        clear            = clr;
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 0, '0, ordy, 1'b0);
    endtask

    initial begin
        bus.istream_val  = 1'b0;
        bus.istream_idx  = '0;
        bus.istream_data = '0;
        bus.ostream_rdy  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_val",  LINE_W'(bus.ostream_val), '0);
        check("reset_rdy",  LINE_W'(bus.istream_rdy), '0);
        check("reset_cnt",  LINE_W'(fill_count), '0);
        check("reset_line", bus.ostream_line, '0);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);

        // In-order fill with the consumer always ready
        for (int i = 0; i < 4; i++) drive(1'b1, i, DATA_W'(32'hA0 + i), 1'b1, 1'b0);
        check("inorder_val",  LINE_W'(bus.ostream_val), LINE_W'(1));
        check("inorder_line", bus.ostream_line, 128'h000000A3_000000A2_000000A1_000000A0);
        idle(1'b1);
        check("inorder_back_cnt", LINE_W'(fill_count), '0);
        check("inorder_back_rdy", LINE_W'(bus.istream_rdy), LINE_W'(1));

        // Out-of-order with backpressure; offered words during FULL are ignored
        drive(1'b1, 2, 32'h22, 1'b0, 1'b0);
        drive(1'b1, 0, 32'h00, 1'b0, 1'b0);
        drive(1'b1, 3, 32'h33, 1'b0, 1'b0);
        drive(1'b1, 1, 32'h11, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("ooo_line", bus.ostream_line, 128'h00000033_00000022_00000011_00000000);
            check("ooo_rdy",  LINE_W'(bus.istream_rdy), '0);
            drive(1'b1, i, 32'hDEAD, 1'b0, 1'b0);
        end
        idle(1'b1);
        check("ooo_consumed", LINE_W'(bus.ostream_val), '0);

        // Duplicate index
        drive(1'b1, 1, 32'h5, 1'b0, 1'b0);
        drive(1'b1, 1, 32'h9, 1'b0, 1'b0);
        check("dup_cnt", LINE_W'(fill_count), LINE_W'(1));
        check("dup_err", LINE_W'(err_dup), LINE_W'(1));
        drive(1'b1, 0, 32'h4, 1'b0, 1'b0);
        drive(1'b1, 2, 32'h6, 1'b0, 1'b0);
        drive(1'b1, 3, 32'h7, 1'b0, 1'b0);
        check("dup_line", bus.ostream_line, 128'h00000007_00000006_00000005_00000004);
        idle(1'b1);
        check("dup_err_cleared", LINE_W'(err_dup), '0);

        // Clear mid-line drops the word offered with it
        drive(1'b1, 0, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 2, 32'h12, 1'b0, 1'b1);
        check("clr_cnt",  LINE_W'(fill_count), '0);
        check("clr_line", bus.ostream_line, '0);
        check("clr_rdy",  LINE_W'(bus.istream_rdy), LINE_W'(1));

        // Clear beats consume: the line is not delivered
        for (int i = 0; i < 4; i++) drive(1'b1, i, $urandom, 1'b0, 1'b0);
        drive(1'b0, 0, '0, 1'b1, 1'b1);
        check("clrcons_val",   LINE_W'(bus.ostream_val), '0);
        check("clrcons_line",  bus.ostream_line, '0);
        check("clrcons_deliv", LINE_W'(deliv_dut), LINE_W'(3));
        check("model_deliv",   LINE_W'(deliv_m), LINE_W'(3));

        // Asynchronous reset in the middle of a line with err_dup set
        drive(1'b1, 0, 32'h1, 1'b0, 1'b0);
        drive(1'b1, 0, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 1, 32'h3, 1'b0, 1'b0);
        check("pre_rst_err", LINE_W'(err_dup), LINE_W'(1));
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("arst_val", LINE_W'(bus.ostream_val), '0);
        check("arst_cnt", LINE_W'(fill_count), '0);
        check("arst_err", LINE_W'(err_dup), '0);
        @(posedge clk); #2 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) drive(1'b1, 3 - i, DATA_W'(32'hB0 + i), 1'b0, 1'b0);
        check("arst_refill", bus.ostream_line, 128'h000000B0_000000B1_000000B2_000000B3);
        idle(1'b1);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, WORDS - 1)), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
        end
        idle(1'b0);
        check("deliv_total", LINE_W'(deliv_dut), LINE_W'(deliv_m));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
